// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_array
// Brief    : NUM_NEURONS independent leaky integrate-and-fire neurons with
//            shift leak, shared threshold and refractory hold.
//            Optional macro LIF_SPIKE_COUNT_EN adds a saturating spike total.
// Revision : 1.0  initial release
// ============================================================================
module lif_neuron_array #(
   parameter int NUM_NEURONS    = 4,
   parameter int WIDTH          = 8,
   parameter int LEAK_SHIFT     = 1,
   parameter int REFRACT_CYCLES = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [NUM_NEURONS*WIDTH-1:0]  current,
   input  logic [WIDTH-1:0]              threshold,
   output logic [NUM_NEURONS*WIDTH-1:0]  membrane,
   output logic [NUM_NEURONS-1:0]        spike,
   output logic [15:0]                   spike_total
);

   localparam logic [WIDTH:0] c_SAT     = {1'b0, {WIDTH{1'b1}}};
   localparam logic [3:0]     c_REFRACT = 4'(REFRACT_CYCLES);

   typedef enum logic [0:0] {
      ST_INTEGRATE = 1'b0,
      ST_REFRACT   = 1'b1
   } state_t;

`ifdef LIF_SPIKE_COUNT_EN
   logic [NUM_NEURONS-1:0] w_spike_vec_nxt;
`endif

   for (genvar g_i = 0; g_i < NUM_NEURONS; g_i++) begin : g_neuron
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_mem;
      logic [WIDTH-1:0] w_mem_nxt;
      logic [3:0]       r_cnt;
      logic [3:0]       w_cnt_nxt;
      logic             r_spike;
      logic             w_spike_nxt;
      logic [WIDTH-1:0] w_cur;
      logic [WIDTH:0]   w_sum;
      logic [WIDTH:0]   w_sat;

      assign w_cur = current[g_i*WIDTH +: WIDTH];
      // One extra bit of headroom: leaked membrane plus current never exceeds it
      assign w_sum = {1'b0, r_mem} - {1'b0, (r_mem >> LEAK_SHIFT)} + {1'b0, w_cur};
      assign w_sat = w_sum[WIDTH] ? c_SAT : w_sum;

      always_comb begin
         w_state_nxt = r_state;
         w_mem_nxt   = r_mem;
         w_cnt_nxt   = r_cnt;
         w_spike_nxt = 1'b0;
         if (en) begin
            case (r_state)
               ST_REFRACT: begin
                  w_mem_nxt = '0;
                  w_cnt_nxt = r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     w_state_nxt = ST_INTEGRATE;
                  end
               end
               default: begin
                  if (w_sat >= {1'b0, threshold}) begin
                     w_spike_nxt = 1'b1;
                     w_mem_nxt   = '0;
                     w_cnt_nxt   = c_REFRACT;
                     w_state_nxt = (c_REFRACT != 4'd0) ? ST_REFRACT : ST_INTEGRATE;
                  end else begin
                     w_mem_nxt = w_sat[WIDTH-1:0];
                  end
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_state <= ST_INTEGRATE;
            r_mem   <= '0;
            r_cnt   <= '0;
            r_spike <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_mem   <= w_mem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_spike <= w_spike_nxt;
         end
      end

      assign membrane[g_i*WIDTH +: WIDTH] = r_mem;
      assign spike[g_i]                   = r_spike;
`ifdef LIF_SPIKE_COUNT_EN
      assign w_spike_vec_nxt[g_i]         = w_spike_nxt;
`endif
   end : g_neuron

`ifdef LIF_SPIKE_COUNT_EN
   logic [3:0]  w_pop;
   logic [16:0] w_total_sum;
   logic [15:0] r_total;

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
         w_pop = w_pop + 4'(w_spike_vec_nxt[k]);
      end
   end

   // Counts the spikes being registered this edge so the total tracks spike
   assign w_total_sum = {1'b0, r_total} + {13'd0, w_pop};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_total <= '0;
      end else begin
         r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
      end
   end

   assign spike_total = r_total;
`else
   assign spike_total = 16'd0;
`endif

endmodule
`default_nettype wire
